// File: rtl/vx_tma_uop_seq_pkg.sv
// Shared types and constants for the TMA launch-op expander.
// Holds the ibuffer_t payload, TMA micro-op opcodes and sizing helpers.
package vx_tma_uop_seq_pkg;

  localparam int unsigned UUID_WIDTH     = 44;
  localparam int unsigned NW_BITS        = 2;
  localparam int unsigned NUM_THREADS    = 4;
  localparam int unsigned PC_BITS        = 32;
  localparam int unsigned EX_BITS        = 2;
  localparam int unsigned INST_OP_BITS   = 4;
  localparam int unsigned INST_ARGS_BITS = 16;
  localparam int unsigned REG_BITS       = 6;

  // Coordinates live in the F bank (upper half of the register index space).
  localparam bit EXT_F_ENABLE = 1'b1;
  localparam bit UUID_ENABLE  = 1'b1;

  localparam int unsigned TMA_UOP_OP_BITS  = 3;
  localparam int unsigned TMA_UOP_IDX_LSB  = 3;
  localparam int unsigned TMA_UOP_IDX_BITS = 3;
  localparam int unsigned TMA_DIMS_BITS    = 3;
  // Clamped dims can reach 8, so one bit wider than the raw field.
  localparam int unsigned DIMS_W           = 4;

  localparam logic [TMA_UOP_OP_BITS-1:0] TMA_UOP_SETUP0 = 3'd0;
  localparam logic [TMA_UOP_OP_BITS-1:0] TMA_UOP_SETUP1 = 3'd1;
  localparam logic [TMA_UOP_OP_BITS-1:0] TMA_UOP_COORD  = 3'd2;
  localparam logic [TMA_UOP_OP_BITS-1:0] TMA_UOP_ISSUE  = 3'd4;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]     uuid;
    logic [NW_BITS-1:0]        wid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [PC_BITS-1:0]        PC;
    logic [EX_BITS-1:0]        ex_type;
    logic [INST_OP_BITS-1:0]   op_type;
    logic [INST_ARGS_BITS-1:0] op_args;
    logic                      wb;
    logic                      rd_xregs;
    logic                      wr_xregs;
    logic [2:0]                used_rs;
    logic [REG_BITS-1:0]       rd;
    logic [REG_BITS-1:0]       rs1;
    logic [REG_BITS-1:0]       rs2;
    logic [REG_BITS-1:0]       rs3;
  } ibuffer_t;

  // Total micro-ops for an already clamped dims value: SETUP0, SETUP1, ceil(d/2) COORD/ISSUE.
  function automatic int unsigned tma_uop_count(input logic [DIMS_W-1:0] dims);
    return 2 + ((32'(dims) + 1) / 2);
  endfunction

  // Counter width able to index every micro-op of the longest sequence.
  function automatic int unsigned tma_ctr_width(input int unsigned max_dims);
    return $clog2(2 + ((max_dims + 1) / 2));
  endfunction

endpackage

// File: rtl/vx_tma_uop_seq_decode.sv
// Combinational micro-op builder: maps the held launch instruction and the
// sequence counter to one output micro-op.
// Ports:
//   held    - latched launch instruction
//   ctr     - micro-op index within the sequence
//   dims    - clamped tensor dimensionality (1..MAX_DIMS)
//   is_last - ctr addresses the ISSUE micro-op
//   uop     - generated micro-op payload
module vx_tma_uop_seq_decode
  import vx_tma_uop_seq_pkg::*;
#(
  parameter int unsigned MAX_DIMS   = 5,
  parameter int unsigned COORD_BASE = 5,
  parameter int unsigned CTR_W      = tma_ctr_width(MAX_DIMS)
) (
  input  ibuffer_t          held,
  input  logic [CTR_W-1:0]  ctr,
  input  logic [DIMS_W-1:0] dims,
  output logic              is_last,
  output ibuffer_t          uop
);

  localparam int unsigned REG_BASE = (EXT_F_ENABLE ? 32 : 0) + COORD_BASE;

  logic [CTR_W-1:0]           last_idx;
  logic [CTR_W-1:0]           k;
  logic [TMA_UOP_OP_BITS-1:0] op;

  assign last_idx = CTR_W'(tma_uop_count(dims) - 1);
  assign k        = ctr - CTR_W'(2);
  assign is_last  = (ctr == last_idx);

  // Field overrides on top of a pass-through copy of the held instruction.
  always_comb begin
    uop         = held;
    op          = TMA_UOP_SETUP0;
    uop.wb      = 1'b0;
    uop.used_rs = 3'b011;
    uop.rs1     = held.rs2;
    uop.rs2     = held.rs2;
    if (ctr == CTR_W'(1)) begin
      op      = TMA_UOP_SETUP1;
      uop.rs1 = held.rs1;
    end else if (ctr != '0 && is_last) begin
      op = TMA_UOP_ISSUE;
      // Odd rank leaves a single trailing coordinate for ISSUE.
      if (dims[0]) begin
        uop.rs1     = REG_BITS'(REG_BASE + 32'(dims) - 1);
        uop.rs2     = '0;
        uop.used_rs = 3'b001;
      end else begin
        uop.rs1 = REG_BITS'(REG_BASE + 32'(dims) - 2);
        uop.rs2 = REG_BITS'(REG_BASE + 32'(dims) - 1);
      end
    end else if (ctr != '0) begin
      op      = TMA_UOP_COORD;
      uop.rs1 = REG_BITS'(REG_BASE + 2 * 32'(k));
      uop.rs2 = REG_BITS'(REG_BASE + 2 * 32'(k) + 1);
      uop.op_args[TMA_UOP_IDX_LSB +: TMA_UOP_IDX_BITS] = TMA_UOP_IDX_BITS'(k);
    end
    uop.op_args[TMA_UOP_OP_BITS-1:0] = op;
    // Stamp the micro-op index into the uuid so trace tools can tell uops apart.
    if (UUID_ENABLE) begin
      uop.uuid[31:0] = {ctr, held.uuid[31-CTR_W:0]};
    end
  end

endmodule

// File: rtl/vx_tma_uop_seq.sv
// TMA launch-op expander between ibuffer and scheduler. Latches one launch
// instruction and streams SETUP0, SETUP1, COORD pairs and ISSUE micro-ops.
// Ports:
//   clk, reset          - clock, async active-high reset
//   flush               - synchronous abort of the current sequence
//   in_valid/in_data/in_ready    - launch instruction handshake
//   out_valid/out_data/out_ready - micro-op handshake
//   out_last            - current micro-op is ISSUE
//   busy                - sequence in progress
module vx_tma_uop_seq
  import vx_tma_uop_seq_pkg::*;
#(
  parameter int unsigned MAX_DIMS   = 5,
  parameter int unsigned COORD_BASE = 5,
  parameter int unsigned DIMS_LSB   = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     in_valid,
  input  ibuffer_t in_data,
  output logic     in_ready,
  output logic     out_valid,
  output ibuffer_t out_data,
  input  logic     out_ready,
  output logic     out_last,
  output logic     busy
);

  localparam int unsigned CTR_W = tma_ctr_width(MAX_DIMS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_n;
  ibuffer_t                 held_q;
  logic [DIMS_W-1:0]        dims_q;
  logic [DIMS_W-1:0]        dims_in;
  logic [TMA_DIMS_BITS-1:0] dims_raw;
  logic [CTR_W-1:0]         ctr_q;
  logic                     dec_last;
  logic                     fire;
  logic                     accept;

  // Out-of-range rank (0 or above MAX_DIMS) runs the full-rank sequence.
  assign dims_raw = in_data.op_args[DIMS_LSB +: TMA_DIMS_BITS];
  assign dims_in  = (dims_raw == '0 || 32'(dims_raw) > MAX_DIMS)
                  ? DIMS_W'(MAX_DIMS) : DIMS_W'(dims_raw);

  assign fire   = out_valid && out_ready;
  assign accept = in_valid && in_ready;

  vx_tma_uop_seq_decode #(
    .MAX_DIMS   (MAX_DIMS),
    .COORD_BASE (COORD_BASE),
    .CTR_W      (CTR_W)
  ) u_decode (
    .held    (held_q),
    .ctr     (ctr_q),
    .dims    (dims_q),
    .is_last (dec_last),
    .uop     (out_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; flush dominates.
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state_n = S_RUN;
        S_RUN:  if (fire && dec_last) state_n = accept ? S_RUN : S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Handshake outputs; a new launch may enter while ISSUE is being taken.
  always_comb begin
    out_valid = (state == S_RUN);
    busy      = (state == S_RUN);
    out_last  = (state == S_RUN) && dec_last;
    in_ready  = !flush && ((state == S_IDLE) || (out_last && out_ready));
  end

  // Held instruction and micro-op counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= '0;
      dims_q <= '0;
      ctr_q  <= '0;
    end else if (flush) begin
      ctr_q <= '0;
    end else if (accept) begin
      held_q <= in_data;
      dims_q <= dims_in;
      ctr_q  <= '0;
    end else if (fire && !dec_last) begin
      ctr_q <= ctr_q + CTR_W'(1);
    end
  end

endmodule
